// File: rtl/axis_checker_if.sv
// AXI4-Stream beat bundle checked by axis_checker.
// The master drives payload and valid, the slave returns ready.
interface axis_checker_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0]   tdata;
  logic [DATA_SIZE/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata, tstrb, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern, full strobes and a
// fixed packet length, and keeps saturating packet/error counters.
module axis_checker #(
  parameter int DATA_SIZE = 32,
  parameter int PKT_LEN   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 s00_axis_enable,
  input  logic                 s00_axis_throttle,
  axis_checker_if.slave        s00_axis,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_flag,
  output logic [DATA_SIZE-1:0] expected
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [DATA_SIZE/8-1:0] FULL_STRB = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state, state_nxt;
  logic                 tready_q, tready_nxt;
  logic [BEAT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [DATA_SIZE-1:0] expected_nxt;
  logic [CNT_WIDTH-1:0] pkt_count_nxt, err_count_nxt;
  logic                 err_flag_nxt;
  logic                 accept, at_last, beat_err, pkt_close;

  assign s00_axis.tready = tready_q;

  always_comb begin
    accept        = (state == RECV) && tready_q && s00_axis.tvalid;
    at_last       = (beat_cnt == LAST_BEAT);
    beat_err      = (s00_axis.tdata != expected) ||
                    (s00_axis.tstrb != FULL_STRB) ||
                    (s00_axis.tlast != at_last);
    pkt_close     = accept && (s00_axis.tlast || at_last);
    state_nxt     = state;
    tready_nxt    = 1'b0;
    beat_cnt_nxt  = beat_cnt;
    expected_nxt  = expected;
    pkt_count_nxt = pkt_count;
    err_count_nxt = err_count;
    err_flag_nxt  = err_flag;

    if (accept) begin
      beat_cnt_nxt = pkt_close ? '0 : beat_cnt + 1'b1;
      // Resync on every beat: a single corrupted word costs two errors, not a whole stream.
      expected_nxt = s00_axis.tdata + 1'b1;
      if (beat_err) begin
        err_flag_nxt = 1'b1;
        if (err_count != CNT_MAX) err_count_nxt = err_count + 1'b1;
      end
    end

    if (pkt_close && (pkt_count != CNT_MAX)) pkt_count_nxt = pkt_count + 1'b1;

    case (state)
      IDLE:    if (s00_axis_enable) state_nxt = RECV;
      RECV:    if (!s00_axis_enable && (beat_cnt_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Ready follows the committed next state, so it drops on the same edge the FSM leaves RECV.
    if (state_nxt == RECV)
      tready_nxt = ((state == IDLE) || !s00_axis_throttle) ? 1'b1 : !tready_q;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state     <= IDLE;
      tready_q  <= 1'b0;
      beat_cnt  <= '0;
      expected  <= '0;
      pkt_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tready_q  <= tready_nxt;
      beat_cnt  <= beat_cnt_nxt;
      expected  <= expected_nxt;
      pkt_count <= pkt_count_nxt;
      err_count <= err_count_nxt;
      err_flag  <= err_flag_nxt;
    end
  end

endmodule

// File: tb/tb_axis_checker.sv
// Bench for axis_checker: directed scenarios plus a randomized stream, checked
// every cycle against a behavioural model of the stream rules.
module tb_axis_checker;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int PL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, en, thr;

  axis_checker_if #(.DATA_SIZE(DW)) ifm();
  axis_checker_if #(.DATA_SIZE(DW)) ifs();

  logic [15:0]   pkt_m, err_m;
  logic          flag_m;
  logic [DW-1:0] exp_m;
  logic [3:0]    pkt_s, err_s;
  logic          flag_s;
  logic [DW-1:0] exp_s;

  // The narrow-counter instance sees exactly the same stream as the main one.
  assign ifs.tdata  = ifm.tdata;
  assign ifs.tstrb  = ifm.tstrb;
  assign ifs.tvalid = ifm.tvalid;
  assign ifs.tlast  = ifm.tlast;

  axis_checker #(.DATA_SIZE(DW), .PKT_LEN(PL), .CNT_WIDTH(16)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(areset), .s00_axis_enable(en),
    .s00_axis_throttle(thr), .s00_axis(ifm.slave), .pkt_count(pkt_m),
    .err_count(err_m), .err_flag(flag_m), .expected(exp_m));

  axis_checker #(.DATA_SIZE(DW), .PKT_LEN(PL), .CNT_WIDTH(4)) dut_sat (
    .s00_axis_aclk(clk), .s00_axis_areset(areset), .s00_axis_enable(en),
    .s00_axis_throttle(thr), .s00_axis(ifs.slave), .pkt_count(pkt_s),
    .err_count(err_s), .err_flag(flag_s), .expected(exp_s));

  bit            m_recv, m_tready, m_acc, m_flag;
  int            m_pos, m_pkt, m_err;
  logic [DW-1:0] m_exp;
  int            compared = 0;
  int            mismatched = 0;
  int            cyc = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: packet position as a plain count, acceptance from the ready rule.
  task automatic modelStep();
    bit nxt_recv;
    m_acc = 1'b0;
    if (areset) begin
      m_recv = 0; m_tready = 0; m_pos = 0; m_exp = '0; m_pkt = 0; m_err = 0; m_flag = 0;
      return;
    end
    if (m_recv && m_tready && ifm.tvalid) begin
      m_acc = 1'b1;
      if (ifm.tdata !== m_exp || ifm.tstrb !== '1 || ifm.tlast !== (m_pos == PL - 1)) begin
        m_err++;
        m_flag = 1'b1;
      end
      m_exp = ifm.tdata + DW'(1);
      if (ifm.tlast || m_pos == PL - 1) begin
        m_pos = 0;
        m_pkt++;
      end else begin
        m_pos++;
      end
    end
    nxt_recv = m_recv ? (en || m_pos != 0) : en;
    m_tready = nxt_recv && (!m_recv || !thr || !m_tready);
    m_recv   = nxt_recv;
  endtask

  task automatic checkOutput();
    checkEq("tready",        64'(ifm.tready), 64'(m_tready));
    checkEq("pkt_count",     64'(pkt_m),      64'(sat(m_pkt, 65535)));
    checkEq("err_count",     64'(err_m),      64'(sat(m_err, 65535)));
    checkEq("err_flag",      64'(flag_m),     64'(m_flag));
    checkEq("expected",      64'(exp_m),      64'(m_exp));
    checkEq("sat_pkt_count", 64'(pkt_s),      64'(sat(m_pkt, 15)));
    checkEq("sat_err_count", 64'(err_s),      64'(sat(m_err, 15)));
    checkEq("sat_err_flag",  64'(flag_s),     64'(m_flag));
    checkEq("sat_expected",  64'(exp_s),      64'(m_exp));
    checkEq("sat_tready",    64'(ifs.tready), 64'(m_tready));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input bit l);
    ifm.tvalid = v;
    ifm.tdata  = d;
    ifm.tstrb  = s;
    ifm.tlast  = l;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, ifm.tdata, '1, 1'b0);
  endtask

  task automatic doReset();
    areset = 1'b1;
    idle();
    idle();
    areset = 1'b0;
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit l);
    bit done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      applyStimulus(1'b1, d, s, l);
      done = m_acc;
    end
    checkEq("beat_accept_bound", 64'(done), 64'd1);
    ifm.tvalid = 1'b0;
  endtask

  task automatic sendRun(input logic [DW-1:0] start, input int n, input int last_idx);
    for (int i = 0; i < n; i++) sendBeat(start + DW'(i), '1, i == last_idx);
  endtask

  initial begin
    logic [DW-1:0] seq, d;
    logic [SW-1:0] s;
    int c0, len;
    bit l;

    areset = 1'b1; en = 1'b0; thr = 1'b0;
    ifm.tvalid = 1'b0; ifm.tdata = '0; ifm.tstrb = '1; ifm.tlast = 1'b0;

    doReset();
    checkEq("rst_tready", 64'(ifm.tready), 64'd0);
    checkEq("rst_pkt",    64'(pkt_m),      64'd0);
    checkEq("rst_exp",    64'(exp_m),      64'd0);

    $display("[TB] clean run");
    en = 1'b1;
    for (int p = 0; p < 4; p++) sendRun(DW'(p * 16), 16, 15);
    idle();
    checkEq("clean_pkt",  64'(pkt_m),  64'd4);
    checkEq("clean_err",  64'(err_m),  64'd0);
    checkEq("clean_flag", 64'(flag_m), 64'd0);
    checkEq("clean_exp",  64'(exp_m),  64'd64);

    $display("[TB] data error");
    doReset();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sendBeat((i == 5) ? DW'('h99) : DW'(i), '1, i == 15);
      if (i == 5) checkEq("derr_first", 64'(err_m), 64'd1);
      if (i == 5) checkEq("derr_resync", 64'(exp_m), 64'h9A);
      if (i == 7) checkEq("derr_recovered", 64'(err_m), 64'd2);
    end
    idle();
    checkEq("derr_err",  64'(err_m),  64'd2);
    checkEq("derr_flag", 64'(flag_m), 64'd1);
    checkEq("derr_pkt",  64'(pkt_m),  64'd1);

    $display("[TB] length errors");
    doReset();
    en = 1'b1;
    sendRun(DW'(0), 10, 9);
    idle();
    checkEq("early_err", 64'(err_m), 64'd1);
    checkEq("early_pkt", 64'(pkt_m), 64'd1);
    sendRun(DW'(10), 16, -1);
    idle();
    checkEq("missing_err", 64'(err_m), 64'd2);
    checkEq("missing_pkt", 64'(pkt_m), 64'd2);
    sendRun(DW'(26), 16, 15);
    checkEq("after_len_err", 64'(err_m), 64'd2);
    checkEq("after_len_pkt", 64'(pkt_m), 64'd3);

    $display("[TB] throttle");
    doReset();
    en = 1'b1; thr = 1'b1;
    idle();
    c0 = cyc;
    sendRun(DW'(0), 16, 15);
    checkEq("thr_cycles", 64'(cyc - c0), 64'd31);
    checkEq("thr_pkt",    64'(pkt_m),    64'd1);
    checkEq("thr_err",    64'(err_m),    64'd0);

    $display("[TB] mid-packet disable and reset");
    doReset();
    en = 1'b1; thr = 1'b1;
    idle();
    sendRun(DW'(0), 8, -1);
    en = 1'b0;
    sendRun(DW'(8), 8, 7);
    checkEq("dis_tready_drop", 64'(ifm.tready), 64'd0);
    idle();
    checkEq("dis_tready_idle", 64'(ifm.tready), 64'd0);
    checkEq("dis_pkt",         64'(pkt_m),      64'd1);
    en = 1'b1; thr = 1'b0;
    idle();
    sendRun(DW'(16), 8, -1);
    areset = 1'b1;
    idle();
    areset = 1'b0;
    checkEq("mrst_pkt",    64'(pkt_m),      64'd0);
    checkEq("mrst_err",    64'(err_m),      64'd0);
    checkEq("mrst_tready", 64'(ifm.tready), 64'd0);
    checkEq("mrst_exp",    64'(exp_m),      64'd0);

    $display("[TB] wrap and saturation");
    doReset();
    en = 1'b1;
    sendRun(DW'('hFFFF_FFF8), 16, 15);
    idle();
    checkEq("wrap_err", 64'(err_m), 64'd1);
    checkEq("wrap_exp", 64'(exp_m), 64'd8);
    for (int p = 0; p < 19; p++) sendRun(DW'(8 + 16 * p), 16, 15);
    idle();
    checkEq("sat_main_pkt", 64'(pkt_m), 64'd20);
    checkEq("sat_narrow_pkt", 64'(pkt_s), 64'd15);

    $display("[TB] randomized stream");
    doReset();
    en = 1'b1;
    seq = DW'($urandom);
    for (int p = 0; p < 40; p++) begin
      thr = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
      for (int i = 0; i < len; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) idle();
        d = ($urandom_range(0, 15) == 0) ? DW'($urandom) : seq;
        s = ($urandom_range(0, 19) == 0) ? SW'($urandom_range(0, (1 << SW) - 2)) : '1;
        l = (i == len - 1) && !((len == 16) && ($urandom_range(0, 5) == 0));
        sendBeat(d, s, l);
        seq = d + DW'(1);
      end
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
